// File: rtl/alu_flags_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_flags_pipe                                             |
// | Brief   : Single-stage ALU with registered result and C/N/Z/V flags, |
// |           valid/ready handshake and multi-word (chained) ADD/SUB.    |
// | Options : ALU_STICKY_V_EN adds the sticky-overflow flag q.           |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module alu_flags_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             chain,
  input  logic             flag_we,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             q
);

  localparam logic [2:0] c_OP_NOTA = 3'b000;
  localparam logic [2:0] c_OP_NOTB = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_XNOR = 3'b101;
  localparam logic [2:0] c_OP_ADD  = 3'b110;
  localparam logic [2:0] c_OP_SUB  = 3'b111;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_c, r_n, r_z, r_v;

  logic             w_accept;
  logic             w_is_arith;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_carry_msb;
  logic [WIDTH-1:0] w_res;
  logic             w_new_c, w_new_v, w_new_z;

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Datapath: subtraction is a + ~b + cin; chained ops take cin from the C flag.
  always_comb begin
    w_is_arith  = (op == c_OP_ADD) || (op == c_OP_SUB);
    w_is_sub    = (op == c_OP_SUB);
    w_b_eff     = w_is_sub ? ~b : b;
    w_cin       = chain ? r_c : w_is_sub;
    w_sum       = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    w_carry_msb = a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
    w_res       = '0;
    case (op)
      c_OP_NOTA: w_res = ~a;
      c_OP_NOTB: w_res = ~b;
      c_OP_AND:  w_res = a & b;
      c_OP_OR:   w_res = a | b;
      c_OP_XOR:  w_res = a ^ b;
      c_OP_XNOR: w_res = ~(a ^ b);
      default:   w_res = w_sum[WIDTH-1:0];
    endcase
    w_new_c = w_is_arith && w_sum[WIDTH];
    w_new_v = w_is_arith && (w_carry_msb ^ w_sum[WIDTH]);
    // Chained arithmetic accumulates Z so a multi-word zero test spans all words.
    w_new_z = (w_res == '0) && (!(chain && w_is_arith) || r_z);
  end

  // Result register and output-valid handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Flag register: clear wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (reset || flag_clr) begin
      r_c <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_v <= 1'b0;
    end else if (w_accept && flag_we) begin
      r_c <= w_new_c;
      r_n <= w_res[WIDTH-1];
      r_z <= w_new_z;
      r_v <= w_new_v;
    end
  end

`ifdef ALU_STICKY_V_EN
  logic r_q;

  // Sticky overflow: set by any flag update with V=1, held until cleared.
  always_ff @(posedge clk) begin
    if (reset || flag_clr) begin
      r_q <= 1'b0;
    end else if (w_accept && flag_we && w_new_v) begin
      r_q <= 1'b1;
    end
  end

  assign q = r_q;
`else
  assign q = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign c         = r_c;
  assign n         = r_n;
  assign z         = r_z;
  assign v         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_flags_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_flags_pipe                                          |
// | Brief   : Scoreboard bench for alu_flags_pipe (WIDTH=8).             |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_flags_pipe;

  localparam int W = 8;
`ifdef ALU_STICKY_V_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, chain, flag_we, flag_clr, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, c, n, z, v, q;
  logic [W-1:0] result;

  typedef struct packed {
    logic [W-1:0] res;
    logic c, n, z, v, q;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         last_acc;
  logic         m_ov, m_c, m_n, m_z, m_v, m_q;
  logic [W-1:0] m_res;

  alu_flags_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .chain(chain), .flag_we(flag_we),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c(c), .n(n), .z(z), .v(v), .q(q)
  );

  always #5 clk = ~clk;

  // Apply one cycle's worth of inputs.
  task automatic set_in(input logic vld, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic ch, input logic fwe,
                        input logic fclr, input logic rdy);
    in_valid = vld; op = o; a = xa; b = xb; chain = ch;
    flag_we = fwe; flag_clr = fclr; out_ready = rdy;
  endtask

  // Advance the reference model by one edge, push accepted results, then step the clock.
  task automatic tick();
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         cin, nc, nv, nz, acc;
    acc      = in_valid && (!m_ov || out_ready);
    last_acc = 1'b0;
    if (reset) begin
      m_ov = 0; m_res = '0; m_c = 0; m_n = 0; m_z = 0; m_v = 0; m_q = 0;
      sb.delete();
    end else if (acc) begin
      last_acc = 1'b1;
      nc = 1'b0; nv = 1'b0; r = '0;
      case (op)
        3'd0: r = ~a;
        3'd1: r = ~b;
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~(a ^ b);
        3'd6: begin
          cin = chain ? m_c : 1'b0;
          t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          r   = t[W-1:0]; nc = t[W];
          nv  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        default: begin
          cin = chain ? m_c : 1'b1;
          t   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
          r   = t[W-1:0]; nc = t[W];
          nv  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
      endcase
      nz    = (r == '0) && ((op[2] && op[1] && chain) ? m_z : 1'b1);
      m_res = r; m_ov = 1'b1;
      if (flag_clr) begin
        m_c = 0; m_n = 0; m_z = 0; m_v = 0; m_q = 0;
      end else if (flag_we) begin
        m_c = nc; m_n = r[W-1]; m_z = nz; m_v = nv;
        if (STICKY && nv) m_q = 1'b1;
      end
      sb.push_back('{r, m_c, m_n, m_z, m_v, m_q});
    end else begin
      if (out_ready) m_ov = 1'b0;
      if (flag_clr) begin
        m_c = 0; m_n = 0; m_z = 0; m_v = 0; m_q = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1, 3'd6, 8'h12, 8'h34, 0, 1, 0, 1);
    tick(); tick();
    n_checks++;
    if ({result, c, n, z, v, q, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {result, c, n, z, v, q, out_valid});
    end
    reset = 1'b0;
    set_in(0, 3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_arith();
    logic [2:0]   t_op [3] = '{3'd6, 3'd7, 3'd7};
    logic [W-1:0] t_a  [3] = '{8'h7F, 8'h05, 8'h00};
    logic [W-1:0] t_b  [3] = '{8'h01, 8'h05, 8'h01};
    exp_t         t_ex [3] = '{'{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, STICKY},
                               '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, STICKY},
                               '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, STICKY}};
    for (int i = 0; i < 3; i++) begin
      set_in(1, t_op[i], t_a[i], t_b[i], 0, 1, 0, 1);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({result, c, n, z, v, q, out_valid} !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL arith_sb[%0d]: got %h expected %h", i, {result, c, n, z, v, q, out_valid}, {e, 1'b1});
      end
      n_checks++;
      if ({result, c, n, z, v, q} !== t_ex[i]) begin
        n_fail++;
        $display("FAIL arith_vec[%0d]: got %h expected %h", i, {result, c, n, z, v, q}, t_ex[i]);
      end
    end
  endtask

  // Two-word add, two-word sub with nonzero high part, and a chained all-zero sub.
  task automatic test_chain();
    logic [2:0]   t_op [6] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [W-1:0] t_a  [6] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h05, 8'h00};
    logic [W-1:0] t_b  [6] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
    logic         t_ch [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t         t_ex [6] = '{'{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, STICKY},
                               '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, STICKY},
                               '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, STICKY},
                               '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, STICKY},
                               '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, STICKY},
                               '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, STICKY}};
    for (int i = 0; i < 6; i++) begin
      set_in(1, t_op[i], t_a[i], t_b[i], t_ch[i], 1, 0, 1);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({result, c, n, z, v, q} !== e || e !== t_ex[i]) begin
        n_fail++;
        $display("FAIL chain[%0d]: got %h expected %h", i, {result, c, n, z, v, q}, t_ex[i]);
      end
    end
  endtask

  // Logic ops with chain=1 and C=1 still pending: chain/cin must be ignored.
  task automatic test_logic();
    for (int i = 0; i < 12; i++) begin
      if (i == 6) set_in(1, 3'd2, 8'hF0, 8'h0F, 1, 1, 0, 1);
      else        set_in(1, 3'(i % 6), 8'($urandom), 8'($urandom), 1, 1, 0, 1);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({result, c, n, z, v, q} !== e) begin
        n_fail++;
        $display("FAIL logic[%0d] op=%0d: got %h expected %h", i, op, {result, c, n, z, v, q}, e);
      end
    end
  endtask

  task automatic test_backpressure();
    set_in(1, 3'd6, 8'h70, 8'h20, 0, 1, 0, 1);
    tick();
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 3'd7, 8'($urandom), 8'($urandom), 0, 1, 1, 0);
      set_in(1, 3'd7, a, b, 0, 1, 0, 0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready);
      end
      tick();
      n_checks++;
      if ({result, c, n, z, v, q, out_valid} !== {e, 1'b1} || last_acc) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, {result, c, n, z, v, q, out_valid}, {e, 1'b1});
      end
    end
    set_in(1, 3'd4, 8'h3C, 8'h0F, 0, 1, 0, 1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({result, c, n, z, v, q, out_valid} !== {e, 1'b1} || result !== 8'h33) begin
      n_fail++;
      $display("FAIL bp_release: got %h expected %h", {result, c, n, z, v, q, out_valid}, {e, 1'b1});
    end
    // flag_we=0: result moves, flags hold.
    set_in(1, 3'd6, 8'hFF, 8'hFF, 0, 0, 0, 1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({result, c, n, z, v, q} !== e || result !== 8'hFE) begin
      n_fail++;
      $display("FAIL no_flag_we: got %h expected %h", {result, c, n, z, v, q}, e);
    end
    set_in(0, 3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flag_clr();
    set_in(1, 3'd6, 8'h7F, 8'h01, 0, 1, 0, 1);
    tick();
    e = sb.pop_front();
    set_in(1, 3'd6, 8'h80, 8'h80, 0, 1, 1, 1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({result, c, n, z, v, q} !== e || {result, c, n, z, v, q} !== {8'h00, 5'b0}) begin
      n_fail++;
      $display("FAIL flag_clr_accept: got %h expected %h", {result, c, n, z, v, q}, {8'h00, 5'b0});
    end
    set_in(1, 3'd7, 8'h00, 8'h01, 0, 1, 0, 1);
    tick();
    e = sb.pop_front();
    set_in(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 1);
    tick();
    n_checks++;
    if ({c, n, z, v, q} !== 5'b0 || result !== 8'hFF) begin
      n_fail++;
      $display("FAIL flag_clr_idle: got %h expected %h", {result, c, n, z, v, q}, {8'hFF, 5'b0});
    end
  endtask

  task automatic test_reset_midstream();
    set_in(1, 3'd6, 8'h7F, 8'h7F, 0, 1, 0, 1);
    tick();
    e = sb.pop_front();
    reset = 1'b1;
    set_in(1, 3'd7, 8'h10, 8'h20, 0, 1, 1, 1);
    tick();
    n_checks++;
    if ({result, c, n, z, v, q, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h expected 0", {result, c, n, z, v, q, out_valid});
    end
    reset = 1'b0;
    set_in(0, 3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
    tick();
  endtask

  // Random traffic with random backpressure; scoreboard for accepted results.
  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 2) != 0));
      #1;
      n_checks++;
      if (in_ready !== (!m_ov || out_ready)) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, in_ready, !m_ov || out_ready);
      end
      tick();
      if (last_acc) e = sb.pop_front();
      else          e = '{m_res, m_c, m_n, m_z, m_v, m_q};
      n_checks++;
      if ({result, c, n, z, v, q, out_valid} !== {e, m_ov}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, {result, c, n, z, v, q, out_valid}, {e, m_ov});
      end
    end
  endtask

  initial begin
    m_ov = 0; m_res = '0; m_c = 0; m_n = 0; m_z = 0; m_v = 0; m_q = 0; last_acc = 0;
    test_reset();
    test_arith();
    test_chain();
    test_logic();
    test_backpressure();
    test_flag_clr();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
